// File: rtl/axil_pkg.sv
// Shared AXI-Lite write-channel definitions: FSM states, response codes and
// address/data/strobe widths used by sw_channel and strb_merge.
package axil_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HAVE_ADDR,
    ST_HAVE_DATA,
    ST_WRITE,
    ST_RESP
  } axil_state_e;

endpackage

// File: rtl/sw_channel_strb_merge.sv
// Byte-strobe merge: each byte of the result comes from the new word when its
// strobe is set, otherwise from the old word. Purely combinational.
module strb_merge
  import axil_pkg::*;
(
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] new_word_i,
  input  logic [STRB_W-1:0] strb_i,
  output logic [DATA_W-1:0] merged_o
);

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_byte
    assign merged_o[8*gi +: 8] = strb_i[gi] ? new_word_i[8*gi +: 8]
                                            : old_word_i[8*gi +: 8];
  end

endmodule

// File: rtl/sw_channel.sv
// AXI-Lite write-only slave into a flop-based register file, one transaction
// outstanding. Define SW_CHANNEL_ADDR_CHECK_EN to reject out-of-range/unaligned writes.
module sw_channel
  import axil_pkg::*;
#(
  parameter int                NREGS   = 16,
  parameter logic [DATA_W-1:0] RST_VAL = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [STRB_W-1:0]            wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [NREGS-1:0][DATA_W-1:0] regs,
  output logic                         wr_pulse,
  output logic [3:0]                   wr_index
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  axil_state_e       state_q, state_d;
  logic              ready_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_pulse_q;
  logic [3:0]        wr_index_q;
  logic [1:0]        bresp_q;

  logic              aw_hs, w_hs;
  logic [IDX_W-1:0]  idx;
  logic              addr_ok;
  logic              commit;
  logic [DATA_W-1:0] merged;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign idx   = addr_q[IDX_W+1:2];

`ifdef SW_CHANNEL_ADDR_CHECK_EN
  assign addr_ok = (int'(addr_q[ADDR_W-1:2]) < NREGS) && (addr_q[1:0] == 2'b00);
`else
  assign addr_ok = 1'b1;
`endif

  assign commit = (state_q == ST_WRITE) && addr_ok;

  // Ready outputs stay low until the first clock edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en_q <= 1'b0;
    else       ready_en_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (aw_hs && w_hs) state_d = ST_WRITE;
        else if (aw_hs)    state_d = ST_HAVE_ADDR;
        else if (w_hs)     state_d = ST_HAVE_DATA;
      end
      ST_HAVE_ADDR: if (w_hs)   state_d = ST_WRITE;
      ST_HAVE_DATA: if (aw_hs)  state_d = ST_WRITE;
      ST_WRITE:                 state_d = ST_RESP;
      ST_RESP:      if (bready) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        awready = ready_en_q;
        wready  = ready_en_q;
      end
      ST_HAVE_ADDR: wready  = ready_en_q;
      ST_HAVE_DATA: awready = ready_en_q;
      ST_RESP:      bvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      if (aw_hs) addr_q <= awaddr;
      if (w_hs) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
    end
  end

  strb_merge u_merge (
    .old_word_i (regs_q[idx]),
    .new_word_i (data_q),
    .strb_i     (strb_q),
    .merged_o   (merged)
  );

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                               regs_q[gi] <= RST_VAL;
      else if (commit && (idx == IDX_W'(gi))) regs_q[gi] <= merged;
    end
    assign regs[gi] = regs_q[gi];
  end

  // Pulse, index and response are captured at the end of WRITE so they line
  // up with the first RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_pulse_q <= commit;
      if (commit) wr_index_q <= 4'(idx);
      if (state_q == ST_WRITE) bresp_q <= addr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign wr_pulse = wr_pulse_q;
  assign wr_index = wr_index_q;
  assign bresp    = bresp_q;

endmodule

// File: tb/tb_sw_channel.sv
// Randomized scoreboard bench for sw_channel: a driver pushes expected
// responses from a register-array model, a negedge monitor pops and compares.
module tb_sw_channel;

  localparam int          NREGS   = 16;
  localparam logic [31:0] RST_VAL = 32'h0000_0000;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [7:0]              awaddr = '0;
  logic                    awvalid = 1'b0;
  logic                    awready;
  logic [31:0]             wdata = '0;
  logic [3:0]              wstrb = '0;
  logic                    wvalid = 1'b0;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready = 1'b0;
  logic [NREGS-1:0][31:0]  regs;
  logic                    wr_pulse;
  logic [3:0]              wr_index;

  sw_channel #(.NREGS(NREGS), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .regs(regs), .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] value;
    logic        pulse;
    logic [1:0]  bresp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [NREGS];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          txn_no = 0;
  bit          hold_mode = 1'b0;
  int          bv_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // bready: random, or held low for the first five cycles of each response.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bvalid) bv_cnt++; else bv_cnt = 0;
      if (hold_mode) bready = (bv_cnt > 5);
      else           bready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: protocol observation on the pins, scoreboard pop on B handshake.
  bit          aw_done = 0, w_done = 0, busy = 0, bv_prev = 0, just_hs = 0, pulse_seen = 0;
  int          hs_cyc = 0;
  logic [1:0]  bresp_prev = '0;
  always @(negedge clk) begin
    if (reset) begin
      aw_done = 0; w_done = 0; busy = 0; bv_prev = 0; just_hs = 0; pulse_seen = 0;
    end else begin
      if (busy) begin
        chk("busy_awready", 32'(awready), 0);
        chk("busy_wready", 32'(wready), 0);
      end else if (aw_done) begin
        chk("have_addr_awready", 32'(awready), 0);
        chk("have_addr_wready", 32'(wready), 1);
      end else if (w_done) begin
        chk("have_data_awready", 32'(awready), 1);
        chk("have_data_wready", 32'(wready), 0);
      end
      if (just_hs) chk("bvalid_drop", 32'(bvalid), 0);
      just_hs = 0;
      if (wr_pulse) begin
        if (exp_q.size() == 0 || !exp_q[0].pulse) begin
          chk("unexpected_wr_pulse", 32'(wr_pulse), 0);
        end else begin
          chk("wr_index", 32'(wr_index), 32'(exp_q[0].idx));
          chk("reg_value", regs[wr_index], exp_q[0].value);
          chk("pulse_latency", 32'(cyc), 32'(hs_cyc + 2));
        end
        pulse_seen = 1;
      end
      if (bvalid) begin
        if (!bv_prev) chk("bvalid_latency", 32'(cyc), 32'(hs_cyc + 2));
        else          chk("bresp_stable", 32'(bresp), 32'(bresp_prev));
        if (bready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_response", 32'(bvalid), 0);
          end else begin
            chk("bresp", 32'(bresp), 32'(exp_q[0].bresp));
            chk("pulse_seen", 32'(pulse_seen), 32'(exp_q[0].pulse));
            $display("txn %0d: idx=%0d bresp=%b pulse=%0d", txn_no, exp_q[0].idx, bresp, pulse_seen);
            void'(exp_q.pop_front());
          end
          txn_no++;
          pulse_seen = 0; busy = 0; bv_prev = 0; just_hs = 1;
        end else begin
          bv_prev = 1; bresp_prev = bresp;
        end
      end else begin
        if (bv_prev) chk("bvalid_held", 32'(bvalid), 1);
        bv_prev = 0;
      end
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done = 1;
      if (aw_done && w_done && !busy) begin
        busy = 1; hs_cyc = cyc; aw_done = 0; w_done = 0;
      end
    end
  end

  task automatic send_aw(input logic [7:0] a, input int dly);
    bit ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awvalid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    if (!ok) chk("aw_timeout", 32'(ok), 1);
    @(posedge clk); #1;
    awvalid = 1'b0; awaddr = 8'($urandom);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    if (!ok) chk("w_timeout", 32'(ok), 1);
    @(posedge clk); #1;
    wvalid = 1'b0; wdata = $urandom;
  endtask

  // Reference: byte-wise merge into the model array, address wrapped to 16 words.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int ad, input int wd);
    exp_t e;
    e.idx = a[5:2];
    e.pulse = 1'b1;
    e.bresp = 2'b00;
`ifdef SW_CHANNEL_ADDR_CHECK_EN
    if (a[7:2] >= 6'(NREGS) || a[1:0] != 2'b00) begin
      e.pulse = 1'b0;
      e.bresp = 2'b10;
    end
`endif
    e.value = model[e.idx];
    for (int b = 0; b < 4; b++)
      if (s[b]) e.value[8*b +: 8] = d[8*b +: 8];
    if (e.pulse) model[e.idx] = e.value;
    exp_q.push_back(e);
    fork
      send_aw(a, ad);
      send_w(d, s, wd);
    join
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("drain", 32'(ok), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREGS; i++) model[i] = RST_VAL;

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_wr_pulse", 32'(wr_pulse), 0);
    chk("rst_wr_index", 32'(wr_index), 0);
    for (int i = 0; i < NREGS; i++) chk("rst_regs", regs[i], RST_VAL);
    repeat (3) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    chk("release_awready", 32'(awready), 0);
    @(posedge clk); #1;
    chk("post_release_awready", 32'(awready), 1);
    chk("post_release_wready", 32'(wready), 1);

    // Same-cycle AW and W
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0);
    drain();
    chk("same_cycle_reg2", regs[2], 32'hDEADBEEF);

    // W three cycles ahead of AW, partial strobes
    do_write(8'h04, 32'h11223344, 4'b0101, 3, 0);
    drain();
    chk("w_first_reg1", regs[1], 32'h00220044);

    // Stalled response, next transaction queued behind it
    hold_mode = 1'b1;
    do_write(8'h14, 32'hCAFEF00D, 4'hF, 0, 1);
    do_write(8'h18, 32'h0BADF00D, 4'hF, 0, 0);
    drain();
    hold_mode = 1'b0;

    // Out-of-range address
    do_write(8'h40, 32'h5A5A5A5A, 4'hF, 0, 0);
    drain();
    chk("oor_reg0", regs[0], model[0]);

    // Back-to-back halves into index 3
    do_write(8'h0C, 32'hAAAA1111, 4'b0011, 0, 0);
    do_write(8'h0C, 32'h2222BBBB, 4'b1100, 0, 0);
    drain();
    chk("halves_reg3", regs[3], 32'h22221111);

    // Randomized traffic
    for (int t = 0; t < 40; t++)
      do_write(8'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    drain();

    // Reset while holding an address
    awaddr = 8'h1C; awvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (awready) break;
    end
    @(posedge clk); #1 awvalid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_awready", 32'(awready), 0);
    chk("mid_rst_wready", 32'(wready), 0);
    chk("mid_rst_bvalid", 32'(bvalid), 0);
    for (int i = 0; i < NREGS; i++) model[i] = RST_VAL;
    for (int i = 0; i < NREGS; i++) chk("mid_rst_regs", regs[i], RST_VAL);
    @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready_back", 32'(awready & wready), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no_late_bvalid", 32'(bvalid), 0);
    end

    // Post-reset write and final register sweep
    @(posedge clk); #1;
    do_write(8'h1C, 32'h01234567, 4'b1001, 1, 0);
    drain();
    for (int i = 0; i < NREGS; i++) chk("final_regs", regs[i], model[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
